// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   state_e : sequencer FSM states
//   REG_W   : width of a MIPS register specifier
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   idex_memread_i : instruction in EX is a load
//   idex_rt_i      : load destination register in EX
//   ifid_rs_i      : rs of the instruction in ID
//   ifid_rt_i      : rt of the instruction in ID
//   lu_o           : ID instruction reads the register the EX load writes
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    output logic             lu_o
);

    // $zero never creates a dependency.
    assign lu_o = idex_memread_i
                & (idex_rt_i != '0)
                & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. Handles load-use
// stalls, taken beq/j flushes resolved in ID, and freezes the pipeline while a
// multi-cycle data memory access is outstanding (with a timeout to ERROR).
// Also keeps a saturating count of stalled cycles.
//
//   state | meaning
//   RUN   | normal flow; hazards decoded from ID/EX/MEM inputs
//   WAIT  | memory access outstanding, pipeline frozen until ack
//   ERROR | memory timed out; frozen until reset
//
// Ports:
//   clk_i, rst_i        : clock, async active-low reset
//   ifid_rs_i/rt_i      : ID source registers
//   idex_memread_i/rt_i : EX load and its destination
//   branch_i, eq_i      : ID beq and its compare result
//   jump_i              : ID j
//   exmem_memread_i/memwrite_i : MEM-stage access
//   dmem_ack_i / dmem_req_o    : data memory handshake
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, freeze_o : pipeline controls
//   error_o             : sticky timeout flag (registered)
//   stall_cnt_o         : saturating stall-cycle count (registered)
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic             branch_i,
    input  logic             eq_i,
    input  logic             jump_i,
    input  logic             exmem_memread_i,
    input  logic             exmem_memwrite_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int                WCNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              error_q, error_d;

    logic mem_op;
    logic mem_stall;
    logic lu;
    logic take;
    logic lu_stall;

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .lu_o           (lu)
    );

    assign mem_op    = exmem_memread_i | exmem_memwrite_i;
    assign mem_stall = mem_op & ~dmem_ack_i;
    assign take      = (branch_i & eq_i) | jump_i;
    // Memory stall outranks load-use; the hazard is retried after the access.
    assign lu_stall  = (state_q == RUN) & ~mem_stall & lu;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) state_d = WAIT;
            end
            WAIT: begin
                if (dmem_ack_i) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    if (wait_cnt_q == WAIT_LAST) state_d = ERROR;
                end
            end
            ERROR: state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        dmem_req_o    = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        case (state_q)
            RUN: begin
                dmem_req_o = mem_op;
                if (mem_stall) begin
                    freeze_o = 1'b1;
                end else if (lu) begin
                    idex_bubble_o = 1'b1;
                end else if (take) begin
                    ifid_flush_o = 1'b1;
                    pc_write_o   = 1'b1;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                end
            end
            WAIT: begin
                dmem_req_o   = 1'b1;
                freeze_o     = ~dmem_ack_i;
                pc_write_o   = dmem_ack_i;
                ifid_write_o = dmem_ack_i;
            end
            ERROR: begin
                freeze_o = 1'b1;
            end
            default: begin
                freeze_o = 1'b1;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((freeze_o | lu_stall) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    assign error_d     = (state_d == ERROR);
    assign error_o     = error_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

    localparam int TO_A = 64;
    localparam int CW_A = 32;
    localparam int TO_B = 4;
    localparam int CW_B = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       idex_memread, branch, eq, jump, ex_rd, ex_wr, ack;

    logic            a_req, a_pcw, a_ifw, a_fl, a_bub, a_frz, a_err;
    logic [CW_A-1:0] a_cnt;
    logic            b_req, b_pcw, b_ifw, b_fl, b_bub, b_frz, b_err;
    logic [CW_B-1:0] b_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
        .idex_memread_i(idex_memread), .idex_rt_i(idex_rt),
        .branch_i(branch), .eq_i(eq), .jump_i(jump),
        .exmem_memread_i(ex_rd), .exmem_memwrite_i(ex_wr),
        .dmem_ack_i(ack), .dmem_req_o(a_req),
        .pc_write_o(a_pcw), .ifid_write_o(a_ifw), .ifid_flush_o(a_fl),
        .idex_bubble_o(a_bub), .freeze_o(a_frz),
        .error_o(a_err), .stall_cnt_o(a_cnt)
    );

    pipeline_sequencer #(.TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
        .idex_memread_i(idex_memread), .idex_rt_i(idex_rt),
        .branch_i(branch), .eq_i(eq), .jump_i(jump),
        .exmem_memread_i(ex_rd), .exmem_memwrite_i(ex_wr),
        .dmem_ack_i(ack), .dmem_req_o(b_req),
        .pc_write_o(b_pcw), .ifid_write_o(b_ifw), .ifid_flush_o(b_fl),
        .idex_bubble_o(b_bub), .freeze_o(b_frz),
        .error_o(b_err), .stall_cnt_o(b_cnt)
    );

    // Reference model: "pending" = memory access outstanding, "dead" = timed out.
    typedef struct {
        bit     pending;
        bit     dead;
        int     waited;
        longint cnt;
    } mdl_t;

    typedef struct {
        bit req, pcw, ifw, fl, bub, frz, lu_stall, mem_stall;
    } exp_t;

    mdl_t ma, mb;

    function automatic exp_t expect_out(mdl_t m);
        exp_t e;
        bit mem_op, lu, take;
        e = '{default: 0};
        mem_op = ex_rd | ex_wr;
        lu     = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        take   = (branch && eq) || jump;
        if (m.dead) begin
            e.frz = 1;
        end else if (m.pending) begin
            e.req = 1;
            e.frz = !ack;
            e.pcw = ack;
            e.ifw = ack;
        end else begin
            e.req = mem_op;
            if (mem_op && !ack) begin
                e.frz = 1;
                e.mem_stall = 1;
            end else if (lu) begin
                e.bub = 1;
                e.lu_stall = 1;
            end else if (take) begin
                e.fl  = 1;
                e.pcw = 1;
            end else begin
                e.pcw = 1;
                e.ifw = 1;
            end
        end
        return e;
    endfunction

    function automatic mdl_t advance(mdl_t m, int tmo, longint maxc);
        exp_t e = expect_out(m);
        if (e.frz || e.lu_stall) m.cnt = (m.cnt >= maxc) ? maxc : m.cnt + 1;
        if (m.dead) begin
        end else if (m.pending) begin
            if (ack) begin
                m.pending = 0;
                m.waited  = 0;
            end else if (m.waited == tmo - 1) begin
                m.pending = 0;
                m.dead    = 1;
            end else begin
                m.waited++;
            end
        end else if (e.mem_stall) begin
            m.pending = 1;
            m.waited  = 0;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_comb();
        exp_t ea, eb;
        ea = expect_out(ma);
        eb = expect_out(mb);
        chk("a_req", 64'(a_req), 64'(ea.req));
        chk("a_pc_write", 64'(a_pcw), 64'(ea.pcw));
        chk("a_ifid_write", 64'(a_ifw), 64'(ea.ifw));
        chk("a_flush", 64'(a_fl), 64'(ea.fl));
        chk("a_bubble", 64'(a_bub), 64'(ea.bub));
        chk("a_freeze", 64'(a_frz), 64'(ea.frz));
        chk("b_req", 64'(b_req), 64'(eb.req));
        chk("b_pc_write", 64'(b_pcw), 64'(eb.pcw));
        chk("b_ifid_write", 64'(b_ifw), 64'(eb.ifw));
        chk("b_flush", 64'(b_fl), 64'(eb.fl));
        chk("b_bubble", 64'(b_bub), 64'(eb.bub));
        chk("b_freeze", 64'(b_frz), 64'(eb.frz));
    endtask

    task automatic check_regs();
        chk("a_error", 64'(a_err), 64'(ma.dead));
        chk("a_stall_cnt", 64'(a_cnt), 64'(ma.cnt));
        chk("b_error", 64'(b_err), 64'(mb.dead));
        chk("b_stall_cnt", 64'(b_cnt), 64'(mb.cnt));
    endtask

    // Called right after a falling edge with inputs already applied.
    task automatic step();
        #1;
        check_comb();
        @(posedge clk);
        ma = advance(ma, TO_A, (64'd1 << CW_A) - 1);
        mb = advance(mb, TO_B, (64'd1 << CW_B) - 1);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic clr();
        ifid_rs = 0; ifid_rt = 0; idex_rt = 0;
        idex_memread = 0; branch = 0; eq = 0; jump = 0;
        ex_rd = 0; ex_wr = 0; ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        #1;
        check_comb();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    longint base;

    initial begin
        clr();
        rst_n = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        @(negedge clk);
        do_reset();

        // Load-use on rs
        idex_memread = 1; idex_rt = 8; ifid_rs = 8;
        step();
        chk("lu_cnt_one", 64'(a_cnt), 64'd1);
        idex_memread = 0;
        step();
        // Load-use with $zero destination: no stall
        idex_memread = 1; idex_rt = 0; ifid_rs = 0;
        #1;
        chk("lu_zero_pcw", 64'(a_pcw), 64'd1);
        step();
        clr();

        // Taken beq, then beq + load-use
        branch = 1; eq = 1;
        #1;
        chk("beq_flush", 64'(a_fl), 64'd1);
        step();
        idex_memread = 1; idex_rt = 9; ifid_rt = 9;
        #1;
        chk("beq_lu_noflush", 64'(a_fl), 64'd0);
        step();
        clr();

        // lw in MEM, ack three cycles after the request
        base = ma.cnt;
        ex_rd = 1;
        repeat (3) step();
        ack = 1;
        #1;
        chk("lw_ack_advance", 64'(a_pcw), 64'd1);
        step();
        chk("lw_cnt_plus3", 64'(a_cnt), 64'(base + 3));
        clr();
        step();

        // Memory stall with load-use and jump pending
        do_reset();
        ex_wr = 1; idex_memread = 1; idex_rt = 4; ifid_rs = 4; jump = 1;
        step();
        step();
        ack = 1;
        step();
        ex_wr = 0; ack = 0;
        #1;
        chk("after_mem_bubble", 64'(a_bub), 64'd1);
        step();
        idex_memread = 0;
        #1;
        chk("then_flush", 64'(a_fl), 64'd1);
        step();
        clr();

        // Timeout: no ack forever
        do_reset();
        ex_rd = 1;
        repeat (64) step();
        chk("err_not_yet", 64'(a_err), 64'd0);
        step();
        chk("err_set", 64'(a_err), 64'd1);
        clr();
        step();
        chk("err_frozen", 64'(a_frz), 64'd1);
        do_reset();
        chk("rst_cnt_clr", 64'(a_cnt), 64'd0);
        chk("rst_err_clr", 64'(a_err), 64'd0);

        // Saturation of the 4-bit counter
        idex_memread = 1; idex_rt = 3; ifid_rt = 3;
        repeat (20) step();
        chk("b_saturated", 64'(b_cnt), 64'd15);
        chk("a_twenty", 64'(a_cnt), 64'd20);
        clr();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end
            ifid_rs      = 5'($urandom_range(0, 3));
            ifid_rt      = 5'($urandom_range(0, 3));
            idex_rt      = 5'($urandom_range(0, 3));
            idex_memread = ($urandom_range(0, 2) == 0);
            branch       = $urandom_range(0, 1) == 1;
            eq           = $urandom_range(0, 1) == 1;
            jump         = ($urandom_range(0, 4) == 0);
            ex_rd        = ($urandom_range(0, 4) == 0);
            ex_wr        = ($urandom_range(0, 5) == 0);
            ack          = ($urandom_range(0, 2) == 0);
            step();
        end
        clr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the instruction decoder and drives the PC and pipeline-register enables. It owns three hazard cases:
- load-use hazards in ID;
- control flushes for a taken `beq` or `j` resolved in ID;
- a req/ack handshake to a multi-cycle data memory, which freezes the whole pipeline until the access completes or times out.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum number of WAIT cycles before the error state is entered.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `ifid_rs_i`, `ifid_rt_i` input 5 each: source registers of the instruction in ID.
- `idex_memread_i` input 1: instruction in EX is `lw`.
- `idex_rt_i` input 5: destination register of the instruction in EX.
- `branch_i` input 1: ID instruction is `beq`.
- `eq_i` input 1: ID register comparison result is equal.
- `jump_i` input 1: ID instruction is `j`.
- `exmem_memread_i`, `exmem_memwrite_i` input 1 each: MEM-stage access request.
- `dmem_ack_i` input 1: data memory has completed the access in this cycle.
- `dmem_req_o` output 1: access request to the data memory.
- `pc_write_o` output 1: PC load enable.
- `ifid_write_o` output 1: IF/ID register load enable.
- `ifid_flush_o` output 1: zero the IF/ID register.
- `idex_bubble_o` output 1: force the ID/EX control bits to 0.
- `freeze_o` output 1: hold ID/EX, EX/MEM and MEM/WB.
- `error_o` output 1: timeout occurred; sticky until reset.
- `stall_cnt_o` output `CNT_W`: count of stalled cycles.

## Operation
States: RUN, WAIT, ERROR. Reset state is RUN.

Derived terms:
- `mem_op = exmem_memread_i | exmem_memwrite_i`.
- `lu = idex_memread_i & (idex_rt_i != 0) & (idex_rt_i == ifid_rs_i | idex_rt_i == ifid_rt_i)`.
- `take = (branch_i & eq_i) | jump_i`.

Behaviour in RUN:
- `dmem_req_o = mem_op`.
- `mem_stall = mem_op & ~dmem_ack_i`. If `mem_stall`: `freeze_o=1`, `pc_write_o=0`, `ifid_write_o=0`, and the next state is WAIT.
- Else if `lu`: `pc_write_o=0`, `ifid_write_o=0`, `idex_bubble_o=1`.
- Else if `take`: `ifid_flush_o=1`, `pc_write_o=1`.
- Otherwise `pc_write_o=1`, `ifid_write_o=1`, and the remaining outputs are 0.

Priority is memory stall > load-use > flush:
- The flush is suppressed under a load-use stall because the branch is re-evaluated the next cycle.
- `idex_bubble_o` and `ifid_flush_o` are 0 whenever `freeze_o=1`.

Behaviour in WAIT:
- `dmem_req_o=1` and `freeze_o = ~dmem_ack_i`. `pc_write_o` and `ifid_write_o` equal `dmem_ack_i`. The bubble and flush outputs are 0.
- `wait_cnt` increments each WAIT cycle.
- On `dmem_ack_i`: go to RUN and clear `wait_cnt`. The pipeline advances in the ack cycle and the MEM/WB register captures the memory data.
- If `wait_cnt == TIMEOUT-1` and there is no ack, go to ERROR.

Behaviour in ERROR:
- `freeze_o=1`, `pc_write_o=0`, `ifid_write_o=0`, `dmem_req_o=0`, `error_o=1`.
- The state is left only by reset.

Stall counter:
- `stall_cnt_o` increments by 1 on every clock edge where `freeze_o | lu_stall` was asserted. `lu_stall` is the load-use branch taken in RUN.
- It saturates at all-ones and does not wrap.
- ERROR cycles also count.

## Timing
- Every output except `error_o` and `stall_cnt_o` is combinational from the state and the inputs, in the same cycle.
- `error_o` and `stall_cnt_o` are registered.
- Reset values: state RUN, `wait_cnt=0`, `stall_cnt_o=0`, `error_o=0`. The combinational outputs follow the RUN decode while reset is held.
- Zero-wait memory (ack in the same cycle as req in RUN) adds no stall cycles.
- An ack arriving N cycles after the request adds exactly N freeze cycles.
- A load-use stall lasts exactly one cycle: next cycle `idex_memread_i=0` because of the bubble.
- A memory stall and a load-use hazard in the same cycle: freeze only. The load-use hazard is resolved after the memory completes.
- Reset asserted mid-WAIT: return to RUN immediately and abandon `dmem_req_o`. The memory must also be reset.
- `TIMEOUT=1`: the first WAIT cycle without an ack goes to ERROR.

## Structure
- Package `pipe_ctrl_pkg`: state enum `{RUN, WAIT, ERROR}` and `REG_W = 5`.
- Sub-module `hazard_detect`: purely combinational. It computes `lu` from the ID/EX and IF/ID fields. The sequencer instantiates it once.
- The FSM, `wait_cnt` (width `$clog2(TIMEOUT)+1`) and the stall counter live in `pipeline_sequencer`.

## Test plan
- Load-use: `idex_memread_i=1`, `idex_rt_i=8`, `ifid_rs_i=8` → one cycle with `pc_write_o=0`, `ifid_write_o=0`, `idex_bubble_o=1`; `stall_cnt_o` goes from 0 to 1. Repeat with `idex_rt_i=0` → no stall.
- Taken `beq` (`branch_i=1`, `eq_i=1`) → `ifid_flush_o=1` and `pc_write_o=1` for one cycle. Add `lu=1` in the same cycle → no flush, stall only.
- `lw` in MEM with ack 3 cycles after the request → `freeze_o=1` for 3 cycles and `dmem_req_o` held high for 4 cycles. The pipeline advances in the ack cycle; `stall_cnt_o` increases by 3.
- Memory stall coinciding with a load-use hazard and a `jump_i` → freeze only. After the ack, one load-use stall cycle, then the flush.
- No ack for 64 cycles → ERROR entered, `error_o=1` on the next edge, `freeze_o` stuck at 1. Asserting `rst_i=0` → RUN, counters cleared.
- Preload `stall_cnt_o` near saturation (`CNT_W=4`) with 20 stall cycles → the counter holds at 15.
